// File: rtl/sync_gen_if.sv
// Control/status bundle between the line/frame timing generator and its host.
// The master side drives configuration and start/stop; the slave side is sync_gen.
`timescale 1ns/1ps
interface sync_gen_if #(
  parameter int PIX_W = 12,
  parameter int LN_W  = 11
);
  logic             start;
  logic             stop;
  logic             continuous;
  logic [PIX_W-1:0] pix_per_line;
  logic [LN_W-1:0]  lines_per_frame;
  logic [7:0]       hblank;
  logic             f_sync;
  logic             sync;
  logic             endLine;
  logic             endFrame;
  logic             busy;
  logic [PIX_W-1:0] pix_idx;
  logic [LN_W-1:0]  line_idx;

  modport master (
    output start, stop, continuous, pix_per_line, lines_per_frame, hblank,
    input  f_sync, sync, endLine, endFrame, busy, pix_idx, line_idx
  );

  modport slave (
    input  start, stop, continuous, pix_per_line, lines_per_frame, hblank,
    output f_sync, sync, endLine, endFrame, busy, pix_idx, line_idx
  );
endinterface

// File: rtl/sync_gen.sv
// Line/frame timing generator: sync/f_sync/endLine/endFrame strobes and pixel/line indices.
// Define SYNC_GEN_VBLANK_EN to insert a VBLANK_CYC-cycle vertical blanking state per frame.
//
//   state    | meaning
//   ---------+---------------------------------------------------
//   S_IDLE   | waiting for start, outputs quiet
//   S_SYNC   | one-cycle line-start strobe (f_sync on line 0)
//   S_ACTIVE | P active pixels, pix_idx counting up
//   S_HBLANK | H blanking cycles, endLine (endFrame on last line)
//   S_VBLANK | VBLANK_CYC cycles after the last line (macro only)
`timescale 1ns/1ps
module sync_gen #(
  parameter int PIX_W      = 12,
  parameter int LN_W       = 11,
  parameter int VBLANK_CYC = 64
) (
  input  logic        clk,
  input  logic        rst_n,
  sync_gen_if.slave   bus
);

  localparam int VB_W   = $clog2(VBLANK_CYC + 1);
  localparam int TMR_W0 = (PIX_W > 8) ? PIX_W : 8;
  localparam int TMR_W  = (TMR_W0 > VB_W) ? TMR_W0 : VB_W;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_SYNC   = 3'd1,
    S_ACTIVE = 3'd2,
    S_HBLANK = 3'd3
`ifdef SYNC_GEN_VBLANK_EN
    , S_VBLANK = 3'd4
`endif
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [TMR_W-1:0] r_tmr;
  logic [TMR_W-1:0] w_tmr_nxt;
  logic [PIX_W-1:0] r_p;
  logic [LN_W-1:0]  r_l;
  logic [7:0]       r_h;
  logic             r_cont;
  logic             r_stop_pend;
  logic [LN_W-1:0]  r_line;
  logic [LN_W-1:0]  w_line_nxt;
  logic [PIX_W-1:0] r_pix;
  logic [PIX_W-1:0] w_pix_nxt;
  logic             r_f_sync, r_sync, r_end_line, r_end_frame, r_busy;
  logic             w_f_sync_nxt, w_sync_nxt, w_end_line_nxt, w_end_frame_nxt, w_busy_nxt;
  logic             w_tmr_tc;
  logic             w_last_line;
  logic             w_stop_any;
  logic             w_frame_start;
  logic [PIX_W-1:0] w_p_eff;
  logic [LN_W-1:0]  w_l_eff;
  logic [7:0]       w_h_eff;

  assign w_tmr_tc    = (r_tmr == '0);
  assign w_last_line = (r_line == (r_l - LN_W'(1)));
  assign w_stop_any  = r_stop_pend | bus.stop;
  assign w_p_eff     = (bus.pix_per_line == '0)    ? PIX_W'(1) : bus.pix_per_line;
  assign w_l_eff     = (bus.lines_per_frame == '0) ? LN_W'(1)  : bus.lines_per_frame;
  assign w_h_eff     = (bus.hblank == '0)          ? 8'd1      : bus.hblank;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_line_nxt  = r_line;
    case (r_state)
      S_IDLE: begin
        if (bus.start) begin
          w_state_nxt = S_SYNC;
          w_line_nxt  = '0;
        end
      end
      S_SYNC: w_state_nxt = S_ACTIVE;
      S_ACTIVE: begin
        if (w_tmr_tc) w_state_nxt = S_HBLANK;
      end
      S_HBLANK: begin
        if (w_tmr_tc) begin
          if (!w_last_line) begin
            w_state_nxt = S_SYNC;
            w_line_nxt  = r_line + LN_W'(1);
          end else begin
`ifdef SYNC_GEN_VBLANK_EN
            w_state_nxt = S_VBLANK;
`else
            w_state_nxt = (r_cont && !w_stop_any) ? S_SYNC : S_IDLE;
            w_line_nxt  = '0;
`endif
          end
        end
      end
`ifdef SYNC_GEN_VBLANK_EN
      S_VBLANK: begin
        if (w_tmr_tc) begin
          w_state_nxt = (r_cont && !w_stop_any) ? S_SYNC : S_IDLE;
          w_line_nxt  = '0;
        end
      end
`endif
      default: begin
        w_state_nxt = S_IDLE;
        w_line_nxt  = '0;
      end
    endcase
  end

  // Outputs are computed from the next state so the registered strobes line up with it.
  always_comb begin
    w_frame_start   = (w_state_nxt == S_SYNC) && (w_line_nxt == '0);
    w_sync_nxt      = (w_state_nxt == S_SYNC);
    w_f_sync_nxt    = w_frame_start;
    w_busy_nxt      = (w_state_nxt != S_IDLE);
    w_end_line_nxt  = (w_state_nxt == S_HBLANK);
    w_end_frame_nxt = (w_state_nxt == S_HBLANK) && (w_line_nxt == (r_l - LN_W'(1)));
`ifdef SYNC_GEN_VBLANK_EN
    if (w_state_nxt == S_VBLANK) begin
      w_end_line_nxt  = 1'b1;
      w_end_frame_nxt = 1'b1;
    end
`endif
    w_pix_nxt = '0;
    if (w_state_nxt == S_ACTIVE) begin
      w_pix_nxt = (r_state == S_ACTIVE) ? (r_pix + PIX_W'(1)) : '0;
    end
    w_tmr_nxt = r_tmr;
    if (w_state_nxt != r_state) begin
      case (w_state_nxt)
        S_ACTIVE: w_tmr_nxt = TMR_W'(r_p - PIX_W'(1));
        S_HBLANK: w_tmr_nxt = TMR_W'(r_h - 8'd1);
`ifdef SYNC_GEN_VBLANK_EN
        S_VBLANK: w_tmr_nxt = TMR_W'(VBLANK_CYC - 1);
`endif
        default:  w_tmr_nxt = '0;
      endcase
    end else if (!w_tmr_tc) begin
      w_tmr_nxt = r_tmr - TMR_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_tmr       <= '0;
      r_p         <= PIX_W'(1);
      r_l         <= LN_W'(1);
      r_h         <= 8'd1;
      r_cont      <= 1'b0;
      r_stop_pend <= 1'b0;
      r_line      <= '0;
      r_pix       <= '0;
      r_f_sync    <= 1'b0;
      r_sync      <= 1'b0;
      r_end_line  <= 1'b0;
      r_end_frame <= 1'b0;
      r_busy      <= 1'b0;
    end else begin
      r_tmr       <= w_tmr_nxt;
      r_line      <= w_line_nxt;
      r_pix       <= w_pix_nxt;
      r_f_sync    <= w_f_sync_nxt;
      r_sync      <= w_sync_nxt;
      r_end_line  <= w_end_line_nxt;
      r_end_frame <= w_end_frame_nxt;
      r_busy      <= w_busy_nxt;
      if (w_frame_start) begin
        r_p    <= w_p_eff;
        r_l    <= w_l_eff;
        r_h    <= w_h_eff;
        r_cont <= bus.continuous;
      end
      // start+stop together in IDLE arms the stop so exactly one frame runs
      if (w_state_nxt == S_IDLE) begin
        r_stop_pend <= 1'b0;
      end else if (bus.stop && ((r_state != S_IDLE) || bus.start)) begin
        r_stop_pend <= 1'b1;
      end
    end
  end

  assign bus.f_sync   = r_f_sync;
  assign bus.sync     = r_sync;
  assign bus.endLine  = r_end_line;
  assign bus.endFrame = r_end_frame;
  assign bus.busy     = r_busy;
  assign bus.pix_idx  = r_pix;
  assign bus.line_idx = r_line;

endmodule

// File: tb/tb_sync_gen.sv
// Self-checking bench for sync_gen: table of frame configurations checked cycle by cycle
// against a frame-timing model through an expected-output queue, plus corner sequences.
`timescale 1ns/1ps
module tb_sync_gen;
  localparam int PIX_W = 12;
  localparam int LN_W  = 11;
`ifdef SYNC_GEN_VBLANK_EN
  localparam int VB = 64;
`else
  localparam int VB = 0;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  sync_gen_if #(.PIX_W(PIX_W), .LN_W(LN_W)) sif ();

  sync_gen #(.PIX_W(PIX_W), .LN_W(LN_W), .VBLANK_CYC(64)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (sif)
  );

  always #30 clk = ~clk;

  typedef struct packed {
    logic             f_sync;
    logic             sync;
    logic             end_line;
    logic             end_frame;
    logic             busy;
    logic [PIX_W-1:0] pix;
    logic [LN_W-1:0]  line;
  } outs_t;

  typedef struct {
    int pix;
    int lines;
    int hb;
    bit cont;
    int stop_cyc;
    int extra_start;
    int busy_end;
  } vec_t;

  int    total = 0;
  int    bad   = 0;
  outs_t exp_q[$];
  vec_t  vecs[8];

  function automatic outs_t dut_outs();
    return {sif.f_sync, sif.sync, sif.endLine, sif.endFrame, sif.busy, sif.pix_idx, sif.line_idx};
  endfunction

  // Expected outputs at cycle t, with start sampled at cycle 0.
  function automatic outs_t model(vec_t v, int t);
    outs_t o;
    int p, l, h, lp, fr, f, w, ln, x;
    o = '0;
    if (t < 1) return o;
    p  = (v.pix   < 1) ? 1 : v.pix;
    l  = (v.lines < 1) ? 1 : v.lines;
    h  = (v.hb    < 1) ? 1 : v.hb;
    lp = 1 + p + h;
    fr = l * lp + VB;
    f  = (t - 1) / fr;
    w  = (t - 1) % fr;
    if (f > 0 && !(v.cont && (v.stop_cyc < 0 || v.stop_cyc > f * fr))) return o;
    o.busy = 1'b1;
    if (w >= l * lp) begin
      o.end_line  = 1'b1;
      o.end_frame = 1'b1;
      o.line      = LN_W'(l - 1);
    end else begin
      ln     = w / lp;
      x      = w % lp;
      o.line = LN_W'(ln);
      if (x == 0) begin
        o.sync   = 1'b1;
        o.f_sync = (ln == 0);
      end else if (x <= p) begin
        o.pix = PIX_W'(x - 1);
      end else begin
        o.end_line  = 1'b1;
        o.end_frame = (ln == l - 1);
      end
    end
    return o;
  endfunction

  task automatic check_outs(string name, int t, outs_t got, outs_t exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s t=%0d got fs=%b s=%b el=%b ef=%b bz=%b pix=%0d ln=%0d want fs=%b s=%b el=%b ef=%b bz=%b pix=%0d ln=%0d",
               name, t, got.f_sync, got.sync, got.end_line, got.end_frame, got.busy, got.pix, got.line,
               exp.f_sync, exp.sync, exp.end_line, exp.end_frame, exp.busy, exp.pix, exp.line);
    end
  endtask

  task automatic check_int(string name, int got, int exp);
    total++;
    if (got != exp) begin
      bad++;
      $display("FAIL %s got=%0d want=%0d", name, got, exp);
    end
  endtask

  task automatic run_vec(int idx, vec_t v);
    outs_t got;
    int    prev_busy;
    prev_busy           = 0;
    sif.pix_per_line    = PIX_W'(v.pix);
    sif.lines_per_frame = LN_W'(v.lines);
    sif.hblank          = 8'(v.hb);
    sif.continuous      = v.cont;
    exp_q.delete();
    exp_q.push_back(model(v, 0));
    for (int t = 0; t <= v.busy_end + 5; t++) begin
      @(negedge clk);
      got = dut_outs();
      check_outs($sformatf("vec%0d", idx), t, got, exp_q.pop_front());
      if (t == v.busy_end) check_int($sformatf("vec%0d_busy_end", idx), prev_busy * 2 + int'(got.busy), 2);
      prev_busy  = int'(got.busy);
      sif.start  = (t == 0) || (t == v.extra_start);
      sif.stop   = (t == v.stop_cyc);
      exp_q.push_back(model(v, t + 1));
    end
    sif.start = 1'b0;
    sif.stop  = 1'b0;
    exp_q.delete();
  endtask

  task automatic mid_frame_change();
    int fs[$];
    int maxp0, maxp1;
    bit done;
    maxp0 = 0; maxp1 = 0; done = 0;
    sif.pix_per_line = 12'd4; sif.lines_per_frame = 11'd2; sif.hblank = 8'd2; sif.continuous = 1'b1;
    for (int t = 0; t < 400 && !done; t++) begin
      @(negedge clk);
      if (sif.f_sync) fs.push_back(t);
      if (fs.size() == 1 && int'(sif.pix_idx) > maxp0) maxp0 = int'(sif.pix_idx);
      if (fs.size() == 2 && int'(sif.pix_idx) > maxp1) maxp1 = int'(sif.pix_idx);
      if (t > 2 && !sif.busy) done = 1;
      sif.start = (t == 0);
      sif.stop  = (t == 170);
      if (t == 3) sif.pix_per_line = 12'd8;
    end
    sif.start = 1'b0;
    sif.stop  = 1'b0;
    check_int("mid_done", int'(done), 1);
    check_int("mid_fs0", (fs.size() > 0) ? fs[0] : -1, 1);
    check_int("mid_fs1", (fs.size() > 1) ? fs[1] : -1, (VB == 0) ? 15 : 79);
    check_int("mid_fs2", (fs.size() > 2) ? fs[2] : -1, (VB == 0) ? 37 : 165);
    check_int("mid_maxpix0", maxp0, 3);
    check_int("mid_maxpix1", maxp1, 7);
  endtask

  task automatic reset_mid_frame();
    bit done;
    done = 0;
    sif.pix_per_line = 12'd4; sif.lines_per_frame = 11'd2; sif.hblank = 8'd2; sif.continuous = 1'b0;
    for (int t = 0; t < 4; t++) begin
      @(negedge clk);
      sif.start = (t == 0);
    end
    check_int("pre_rst_busy", int'(sif.busy), 1);
    #10 rst_n = 1'b0;
    #1 check_outs("async_rst", 0, dut_outs(), '0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    sif.start = 1'b1;
    @(negedge clk);
    sif.start = 1'b0;
    check_outs("restart", 1, dut_outs(), {1'b1, 1'b1, 1'b0, 1'b0, 1'b1, PIX_W'(0), LN_W'(0)});
    for (int t = 0; t < 200 && !done; t++) begin
      @(negedge clk);
      if (!sif.busy) done = 1;
    end
    check_int("restart_idle", int'(done), 1);
  endtask

  initial begin
    #(60 * 50000);
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  initial begin
    vecs[0] = '{4, 2, 2, 1'b0, -1,  -1, 15 + VB};
    vecs[1] = '{4, 2, 2, 1'b1, 20,  -1, (VB == 0) ? 29 : 79};
    vecs[2] = '{4, 2, 2, 1'b1, 160, -1, (VB == 0) ? 169 : 235};
    vecs[3] = '{0, 1, 0, 1'b0, -1,  -1, 4 + VB};
    vecs[4] = '{4, 2, 2, 1'b0, -1,   5, 15 + VB};
    vecs[5] = '{4, 2, 2, 1'b1, 0,   -1, 15 + VB};
    vecs[6] = '{3, 3, 5, 1'b0, -1,  -1, 28 + VB};
    vecs[7] = '{0, 2, 0, 1'b1, 7,   -1, (VB == 0) ? 13 : 71};

    sif.start = 1'b0; sif.stop = 1'b0; sif.continuous = 1'b0;
    sif.pix_per_line = '0; sif.lines_per_frame = '0; sif.hblank = '0;
    #100;
    check_outs("reset", 0, dut_outs(), '0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check_outs("post_reset_idle", 0, dut_outs(), '0);

    for (int i = 0; i < 8; i++) run_vec(i, vecs[i]);
    mid_frame_change();
    reset_mid_frame();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
